// File: rtl/i2c_pkg.sv
// Shared I2C slave definitions: FSM state encoding, ACK/NACK line levels, default device address.
// Declarations only; no logic, no latency, no flow control.
package i2c_pkg;

  localparam logic [6:0] I2C_DEF_SLAVE_ADDR = 7'h50;
  localparam logic       I2C_ACK            = 1'b0;
  localparam logic       I2C_NACK           = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_PTR       = 4'd3,
    ST_PTR_ACK   = 4'd4,
    ST_WR_DATA   = 4'd5,
    ST_WR_ACK    = 4'd6,
    ST_RD_DATA   = 4'd7,
    ST_RD_ACK    = 4'd8,
    ST_WAIT_STOP = 4'd9
  } i2c_state_e;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchroniser with edge, START and STOP pulse detection; pulses appear SYNC_STAGES+1 clk after the pad
// change. No backpressure: pulses are single-cycle and unconditional.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_in,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_det_o,
  output logic stop_det_o
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_prev_q;
  logic                   sda_prev_q;
  logic                   scl_s;

  // Reset to 1 so an idle bus produces no spurious edges when reset lifts.
  always_ff @(posedge clk_i or posedge rst_in) begin
    if (rst_in) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_prev_q <= scl_sync_q[SYNC_STAGES-1];
      sda_prev_q <= sda_sync_q[SYNC_STAGES-1];
    end
  end

  assign scl_s       = scl_sync_q[SYNC_STAGES-1];
  assign sda_o       = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise_o  = scl_s & ~scl_prev_q;
  assign scl_fall_o  = ~scl_s & scl_prev_q;
  // Only the current SCL level is qualified, so a bus condition coinciding with an SCL edge still registers.
  assign start_det_o = scl_s & sda_prev_q & ~sda_o;
  assign stop_det_o  = scl_s & ~sda_prev_q & sda_o;

endmodule

// File: rtl/i2c_slave_regctl.sv
// I2C slave register controller: address match, pointer, burst read/write with auto-increment.
// wr_en 1 clk after the 8th synced SCL rise; rd_en on the ACK-bit rise; the master paces everything, no stalls.
module i2c_slave_regctl
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = I2C_DEF_SLAVE_ADDR,
  parameter int         REG_ADDR_W  = 8,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_in,
  input  logic                  scl_in,
  input  logic                  sda_in,
  output logic                  sda_oe,
  output logic                  rd_en,
  input  logic [7:0]            rd_data,
  output logic                  wr_en,
  output logic [7:0]            wr_data,
  output logic [REG_ADDR_W-1:0] reg_addr,
  output logic                  busy
);

  localparam logic [REG_ADDR_W-1:0] PTR_ONE = {{(REG_ADDR_W-1){1'b0}}, 1'b1};

  logic sda_s;
  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;

  i2c_bus_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i       (clk),
    .rst_in      (rst_in),
    .scl_i       (scl_in),
    .sda_i       (sda_in),
    .sda_o       (sda_s),
    .scl_rise_o  (scl_rise),
    .scl_fall_o  (scl_fall),
    .start_det_o (start_det),
    .stop_det_o  (stop_det)
  );

  i2c_state_e            state_q;
  logic [2:0]            bit_cnt_q;
  logic [7:0]            shift_q;
  logic                  phase_q;
  logic                  rw_q;
  logic                  ld_q;
  logic                  sda_oe_q;
  logic                  rd_en_q;
  logic                  wr_en_q;
  logic [7:0]            wr_data_q;
  logic [REG_ADDR_W-1:0] reg_addr_q;
  logic                  busy_q;
  logic [7:0]            rx_byte_d;

  assign rx_byte_d = {shift_q[6:0], sda_s};

  // phase_q splits each ACK slot: 0 = waiting for the fall that opens it, 1 = slot in progress.
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'd0;
      phase_q    <= 1'b0;
      rw_q       <= 1'b0;
      ld_q       <= 1'b0;
      sda_oe_q   <= 1'b0;
      rd_en_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_data_q  <= 8'd0;
      reg_addr_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      ld_q    <= rd_en_q;
      if (wr_en_q) reg_addr_q <= reg_addr_q + PTR_ONE;
      if (ld_q) shift_q <= rd_data;

      if (stop_det) begin
        state_q  <= ST_IDLE;
        sda_oe_q <= 1'b0;
        busy_q   <= 1'b0;
      end else if (start_det) begin
        state_q   <= ST_ADDR;
        bit_cnt_q <= 3'd7;
        sda_oe_q  <= 1'b0;
        phase_q   <= 1'b0;
      end else begin
        unique case (state_q)
          ST_IDLE: ;
          ST_ADDR: begin
            if (scl_rise) begin
              shift_q   <= rx_byte_d;
              bit_cnt_q <= bit_cnt_q - 3'd1;
              if (bit_cnt_q == 3'd0) begin
                rw_q    <= sda_s;
                phase_q <= 1'b0;
                if (rx_byte_d[7:1] == SLAVE_ADDR) begin
                  state_q <= ST_ADDR_ACK;
                  busy_q  <= 1'b1;
                end else begin
                  state_q <= ST_WAIT_STOP;
                  busy_q  <= 1'b0;
                end
              end
            end
          end
          ST_ADDR_ACK: begin
            if (scl_fall) begin
              if (!phase_q) begin
                sda_oe_q <= 1'b1;
                phase_q  <= 1'b1;
              end else begin
                sda_oe_q  <= 1'b0;
                state_q   <= ST_PTR;
                bit_cnt_q <= 3'd7;
              end
            end else if (scl_rise && phase_q && rw_q) begin
              // Read: ACK stays driven; RD_DATA replaces it with bit 7 on the closing fall.
              rd_en_q   <= 1'b1;
              state_q   <= ST_RD_DATA;
              bit_cnt_q <= 3'd7;
            end
          end
          ST_PTR, ST_WR_DATA: begin
            if (scl_rise) begin
              shift_q   <= rx_byte_d;
              bit_cnt_q <= bit_cnt_q - 3'd1;
              if (bit_cnt_q == 3'd0) begin
                phase_q <= 1'b0;
                if (state_q == ST_PTR) begin
                  reg_addr_q <= rx_byte_d[REG_ADDR_W-1:0];
                  state_q    <= ST_PTR_ACK;
                end else begin
                  wr_data_q <= rx_byte_d;
                  wr_en_q   <= 1'b1;
                  state_q   <= ST_WR_ACK;
                end
              end
            end
          end
          ST_PTR_ACK, ST_WR_ACK: begin
            if (scl_fall) begin
              if (!phase_q) begin
                sda_oe_q <= 1'b1;
                phase_q  <= 1'b1;
              end else begin
                sda_oe_q  <= 1'b0;
                state_q   <= ST_WR_DATA;
                bit_cnt_q <= 3'd7;
              end
            end
          end
          ST_RD_DATA: begin
            if (scl_fall) begin
              sda_oe_q  <= ~shift_q[7];
              shift_q   <= {shift_q[6:0], 1'b0};
              bit_cnt_q <= bit_cnt_q - 3'd1;
              if (bit_cnt_q == 3'd0) begin
                state_q <= ST_RD_ACK;
                phase_q <= 1'b0;
              end
            end
          end
          ST_RD_ACK: begin
            if (scl_fall && !phase_q) begin
              sda_oe_q <= 1'b0;
              phase_q  <= 1'b1;
            end else if (scl_rise && phase_q) begin
              if (sda_s == I2C_NACK) begin
                state_q <= ST_WAIT_STOP;
              end else begin
                reg_addr_q <= reg_addr_q + PTR_ONE;
                rd_en_q    <= 1'b1;
                state_q    <= ST_RD_DATA;
                bit_cnt_q  <= 3'd7;
              end
            end
          end
          ST_WAIT_STOP: sda_oe_q <= 1'b0;
          default: begin
            state_q  <= ST_IDLE;
            sda_oe_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sda_oe   = sda_oe_q;
  assign rd_en    = rd_en_q;
  assign wr_en    = wr_en_q;
  assign wr_data  = wr_data_q;
  assign reg_addr = reg_addr_q;
  assign busy     = busy_q;

endmodule
